// File: rtl/dcache_direct_mapped.sv
// rtl/dcache_direct_mapped.sv - direct-mapped write-back write-allocate data cache; optional DCACHE_STATS_EN hit/miss counters
module dcache_direct_mapped #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int SET_ADDR_LEN  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [3:0]  wr_be,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        miss,
  output logic        mem_rd_req,
  output logic        mem_wr_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int WORDS = 1 << LINE_ADDR_LEN;
  localparam int SETS  = 1 << SET_ADDR_LEN;
  localparam int TAG_W = 30 - LINE_ADDR_LEN - SET_ADDR_LEN;
  localparam int IDX_W = LINE_ADDR_LEN + SET_ADDR_LEN;

  typedef enum logic [1:0] {IDLE, WB, FILL} state_e;

  state_e                   state_q, state_d;
  logic [LINE_ADDR_LEN-1:0] cnt_q, cnt_d;
  logic [31:0]              rd_data_q, rd_data_d;
  logic [SETS-1:0]          valid_q, valid_d;
  logic [SETS-1:0]          dirty_q, dirty_d;
  logic [TAG_W-1:0]         tag_q [SETS];
  logic [31:0]              data_q [SETS*WORDS];

  logic [LINE_ADDR_LEN-1:0] req_word;
  logic [SET_ADDR_LEN-1:0]  req_set;
  logic [TAG_W-1:0]         req_tag;
  logic [TAG_W-1:0]         line_tag;
  logic                     line_valid;
  logic                     req;
  logic                     hit;
  logic                     miss_event;
  logic                     tag_we;
  logic                     data_we;
  logic [3:0]               data_be;
  logic [IDX_W-1:0]         data_idx;
  logic [31:0]              data_wdata;
  logic                     unused_addr_bits;

  assign req_word         = addr[LINE_ADDR_LEN+1:2];
  assign req_set          = addr[IDX_W+1:LINE_ADDR_LEN+2];
  assign req_tag          = addr[31:IDX_W+2];
  assign unused_addr_bits = ^addr[1:0];
  assign line_tag         = tag_q[req_set];
  assign line_valid       = valid_q[req_set];
  assign req              = rd_req | wr_req;
  assign hit              = (state_q == IDLE) && req && line_valid && (line_tag == req_tag);
  assign rd_data          = rd_data_q;

  // Next-state, handshake outputs and array write port for IDLE / write-back / refill
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    miss       = 1'b0;
    miss_event = 1'b0;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    tag_we     = 1'b0;
    data_we    = 1'b0;
    data_be    = 4'h0;
    data_idx   = {req_set, req_word};
    data_wdata = wr_data;
    case (state_q)
      IDLE: begin
        if (hit) begin
          if (wr_req) begin
            data_we = 1'b1;
            data_be = wr_be;
            if (|wr_be) dirty_d[req_set] = 1'b1;
          end else begin
            rd_data_d = data_q[{req_set, req_word}];
          end
        end else if (req) begin
          miss       = 1'b1;
          miss_event = 1'b1;
          cnt_d      = '0;
          state_d    = (line_valid && dirty_q[req_set]) ? WB : FILL;
        end
      end
      WB: begin
        miss       = 1'b1;
        mem_wr_req = 1'b1;
        mem_addr   = {line_tag, req_set, cnt_q, 2'b00};
        mem_wdata  = data_q[{req_set, cnt_q}];
        if (mem_ack) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '1) begin
            dirty_d[req_set] = 1'b0;
            state_d          = FILL;
          end
        end
      end
      FILL: begin
        miss       = 1'b1;
        mem_rd_req = 1'b1;
        mem_addr   = {req_tag, req_set, cnt_q, 2'b00};
        if (mem_ack) begin
          data_we    = 1'b1;
          data_be    = 4'hF;
          data_idx   = {req_set, cnt_q};
          data_wdata = mem_rdata;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == '1) begin
            valid_d[req_set] = 1'b1;
            dirty_d[req_set] = 1'b0;
            tag_we           = 1'b1;
            state_d          = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state; a reset mid-transfer drops the partial line by clearing valid
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_data_q <= '0;
      valid_q   <= '0;
      dirty_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
      valid_q   <= valid_d;
      dirty_q   <= dirty_d;
    end
  end

  // Tag array, meaningful only where valid is set
  always_ff @(posedge clk) begin
    if (tag_we) tag_q[req_set] <= req_tag;
  end

  // Data array with byte-lane writes for store hits and full-word refill writes
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (data_we && data_be[b]) data_q[data_idx][8*b +: 8] <= data_wdata[8*b +: 8];
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  // Free-running event counters, wrapping naturally
  always_comb begin
    hit_count_d  = hit_count_q + {31'b0, hit};
    miss_count_d = miss_count_q + {31'b0, miss_event};
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  logic unused_miss_event;
  assign unused_miss_event = miss_event;
`endif

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// tb/tb_dcache_direct_mapped.sv - self-checking bench for dcache_direct_mapped
module tb_dcache_direct_mapped;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req, wr_req;
  logic [3:0]  wr_be;
  logic [31:0] addr, wr_data;
  logic [31:0] rd_data;
  logic        miss;
  logic        mem_rd_req, mem_wr_req;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  dcache_direct_mapped dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req), .wr_be(wr_be),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .miss(miss),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wt;
    int          exp_miss;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  int          mem_wait = 0;
  int          hit_exp = 0;
  int          miss_exp = 0;
  xfer_t       sb[$];
  logic [31:0] mem_m [logic [31:0]];
  logic [15:0] cv, cd;
  logic [22:0] ct [16];
  logic [31:0] cl [16][8];
  vec_t        vecs [18];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a >= 32'h100 && a < 32'h120) return 32'hA0 + ((a - 32'h100) >> 2);
    return {a[15:0], 16'hC300};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return init_word(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference cache: pushes the expected memory transfers and updates its own state
  task automatic model_op(input logic is_wr, input logic [3:0] be, input logic [31:0] a,
                          input logic [31:0] d, output logic was_miss);
    logic [3:0]  s;
    logic [22:0] t;
    logic [2:0]  w;
    logic [31:0] wa;
    xfer_t       x;
    s = a[8:5];
    t = a[31:9];
    w = a[4:2];
    was_miss = !(cv[s] && ct[s] == t);
    if (was_miss) begin
      if (cv[s] && cd[s]) begin
        for (int k = 0; k < 8; k++) begin
          wa = {ct[s], s, k[2:0], 2'b00};
          x.wr = 1'b1; x.addr = wa; x.data = cl[s][k];
          sb.push_back(x);
          mem_m[wa] = cl[s][k];
        end
      end
      for (int k = 0; k < 8; k++) begin
        wa = {t, s, k[2:0], 2'b00};
        x.wr = 1'b0; x.addr = wa; x.data = 32'h0;
        sb.push_back(x);
        cl[s][k] = mem_rd(wa);
      end
      cv[s] = 1'b1;
      cd[s] = 1'b0;
      ct[s] = t;
    end
    if (is_wr) begin
      for (int b = 0; b < 4; b++) if (be[b]) cl[s][w][8*b +: 8] = d[8*b +: 8];
      if (|be) cd[s] = 1'b1;
    end
  endtask

  task automatic do_op(input vec_t v, input int idx);
    int   cnt;
    logic m;
    mem_wait = v.wt;
    model_op(v.wr, v.be, v.addr, v.wdata, m);
    hit_exp++;
    if (m) miss_exp++;
    rd_req  = v.rd;
    wr_req  = v.wr;
    wr_be   = v.be;
    addr    = v.addr;
    wr_data = v.wdata;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!miss) break;
      cnt++;
      if (cnt > 400) break;
    end
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    wr_req = 1'b0;
    check($sformatf("v%0d_miss_cycles", idx), cnt, v.exp_miss);
    if (v.chk_rd) check($sformatf("v%0d_rd_data", idx), rd_data, v.exp_rd);
    check($sformatf("v%0d_xfers_left", idx), sb.size(), 0);
  endtask

  // Word-serial memory: acks after mem_wait idle cycles, scoreboards each transfer
  initial begin
    int    held;
    xfer_t e;
    held = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (rst || !(mem_rd_req || mem_wr_req)) begin
        held = 0;
      end else begin
        check("mem_req_exclusive", {31'b0, mem_rd_req & mem_wr_req}, 32'h0);
        if (mem_rd_req) mem_rdata = mem_rd(mem_addr);
        if (held < mem_wait) begin
          held++;
        end else begin
          held = 0;
          mem_ack = 1'b1;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_xfer: unexpected transfer wr=%0b addr %h, none expected", mem_wr_req, mem_addr);
          end else begin
            e = sb.pop_front();
            check("mem_xfer_kind", {31'b0, mem_wr_req}, {31'b0, e.wr});
            check("mem_addr", mem_addr, e.addr);
            if (e.wr) check("mem_wdata", mem_wdata, e.data);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 4'h0, 32'h100, 32'h0,        0, 9,  1'b1, 32'h000000A0};
    vecs[1]  = '{1'b1, 1'b0, 4'h0, 32'h104, 32'h0,        0, 0,  1'b1, 32'h000000A1};
    vecs[2]  = '{1'b0, 1'b1, 4'h3, 32'h108, 32'hDEADBEEF, 0, 0,  1'b1, 32'h000000A1};
    vecs[3]  = '{1'b1, 1'b0, 4'h0, 32'h108, 32'h0,        0, 0,  1'b1, 32'h0000BEEF};
    vecs[4]  = '{1'b1, 1'b0, 4'h0, 32'h300, 32'h0,        0, 17, 1'b1, 32'h0300C300};
    vecs[5]  = '{1'b0, 1'b1, 4'hF, 32'h500, 32'h12345678, 0, 9,  1'b1, 32'h0300C300};
    vecs[6]  = '{1'b1, 1'b0, 4'h0, 32'h500, 32'h0,        0, 0,  1'b1, 32'h12345678};
    vecs[7]  = '{1'b0, 1'b1, 4'hC, 32'h504, 32'h55667788, 0, 0,  1'b1, 32'h12345678};
    vecs[8]  = '{1'b1, 1'b0, 4'h0, 32'h504, 32'h0,        0, 0,  1'b1, 32'h5566C300};
    vecs[9]  = '{1'b1, 1'b1, 4'h1, 32'h50C, 32'h000000EE, 0, 0,  1'b0, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 4'h0, 32'h50C, 32'h0,        0, 0,  1'b1, 32'h050CC3EE};
    vecs[11] = '{1'b1, 1'b0, 4'h0, 32'h100, 32'h0,        0, 17, 1'b1, 32'h000000A0};
    vecs[12] = '{1'b1, 1'b0, 4'h0, 32'h108, 32'h0,        0, 0,  1'b1, 32'h0000BEEF};
    vecs[13] = '{1'b1, 1'b0, 4'h0, 32'h000, 32'h0,        0, 9,  1'b1, 32'h0000C300};
    vecs[14] = '{1'b0, 1'b1, 4'h0, 32'h004, 32'hFFFFFFFF, 0, 0,  1'b1, 32'h0000C300};
    vecs[15] = '{1'b1, 1'b0, 4'h0, 32'h004, 32'h0,        0, 0,  1'b1, 32'h0004C300};
    vecs[16] = '{1'b1, 1'b0, 4'h0, 32'h200, 32'h0,        0, 9,  1'b1, 32'h0200C300};
    vecs[17] = '{1'b1, 1'b0, 4'h0, 32'h700, 32'h0,        1, 17, 1'b1, 32'h0700C300};

    cv = '0;
    cd = '0;
    rst = 1'b1;
    rd_req = 1'b0;
    wr_req = 1'b0;
    wr_be = 4'h0;
    addr = 32'h0;
    wr_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_rd_data", rd_data, 32'h0);
    check("reset_miss", {31'b0, miss}, 32'h0);
    check("reset_mem_rd_req", {31'b0, mem_rd_req}, 32'h0);
    check("reset_mem_wr_req", {31'b0, mem_wr_req}, 32'h0);
`ifdef DCACHE_STATS_EN
    check("reset_hit_count", hit_count, 32'h0);
    check("reset_miss_count", miss_count, 32'h0);
`endif

    for (int i = 0; i < 18; i++) do_op(vecs[i], i);

`ifdef DCACHE_STATS_EN
    check("hit_count", hit_count, hit_exp);
    check("miss_count", miss_count, miss_exp);
`endif

    begin
      logic m;
      mem_wait = 0;
      model_op(1'b0, 4'h0, 32'h900, 32'h0, m);
      rd_req = 1'b1;
      addr = 32'h900;
      repeat (4) @(posedge clk);
      #1;
      check("abort_fill_word3_addr", mem_addr, 32'h90C);
      rst = 1'b1;
      rd_req = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_miss", {31'b0, miss}, 32'h0);
      check("abort_mem_rd_req", {31'b0, mem_rd_req}, 32'h0);
      check("abort_mem_wr_req", {31'b0, mem_wr_req}, 32'h0);
      check("abort_rd_data", rd_data, 32'h0);
      sb.delete();
      cv = '0;
      cd = '0;
      hit_exp = 0;
      miss_exp = 0;
      do_op('{1'b1, 1'b0, 4'h0, 32'h900, 32'h0, 0, 9, 1'b1, 32'h0900C300}, 100);
`ifdef DCACHE_STATS_EN
      check("post_reset_hit_count", hit_count, hit_exp);
      check("post_reset_miss_count", miss_count, miss_exp);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache_direct_mapped.md
# dcache_direct_mapped

Direct-mapped, write-back, write-allocate data cache between the core's MEM/WB data-memory port and a word-serial main-memory port. It raises `miss`, which drives the core's `DCacheMiss` hazard input, for the whole of any refill or write-back, and it returns load data with the same one-cycle latency as the synchronous data RAM it replaces. On a miss, the cache optionally writes back the dirty victim line, refills the line word by word, and then services the held request as a hit.

## Interface
- `LINE_ADDR_LEN`, default 3: log2 words per line (8 words, 32 B).
- `SET_ADDR_LEN`, default 4: log2 number of sets (16).
- Derived: tag width = 30 − `LINE_ADDR_LEN` − `SET_ADDR_LEN` (23 at defaults).
- Address split: `addr[1:0]` byte, then word offset, then set, then tag (MSBs).

Ports:
- `clk  in  1`: single clock. Reset is synchronous and active-high.
- `rst  in  1`: synchronous, active-high.
- `rd_req  in  1`: load request (core MemToRegM).
- `wr_req  in  1`: store request (core |MemWriteM).
- `wr_be  in  4`: store byte enables (core MemWriteM).
- `addr  in  32`: byte address (core AluOutM).
- `wr_data  in  32`: store data, lane-aligned.
- `rd_data  out  32`: load word, registered.
- `miss  out  1`: stall request to the hazard unit.
- `mem_rd_req  out  1`: memory word read request.
- `mem_wr_req  out  1`: memory word write request.
- `mem_addr  out  32`: word-aligned memory byte address.
- `mem_wdata  out  32`: write-back word.
- `mem_rdata  in  32`: refill word.
- `mem_ack  in  1`: word transfer completes this cycle.

## Operation
- Storage per set: valid, dirty, tag, and 2^`LINE_ADDR_LEN` data words.
- Hit: the request is valid, the line is valid, and the tag matches. Hit is evaluated combinationally in IDLE only.
- FSM states: IDLE, WB, FILL.
- IDLE, no request: `miss`=0.
- IDLE, hit:
  - `miss`=0.
  - Read: selected word is registered into `rd_data`.
  - Write: bytes with `wr_be`=1 are updated and dirty is set. `wr_be`=0000 changes no data and does not set dirty.
- IDLE, miss:
  - `miss`=1 combinationally.
  - Next state is WB if the victim is valid and dirty, otherwise FILL.
- WB:
  - `mem_wr_req`=1, `mem_addr`={victim tag, set, word counter, 00}, `mem_wdata`=victim word.
  - The counter increments on each `mem_ack`.
  - After the last word: clear dirty, go to FILL.
- FILL:
  - `mem_rd_req`=1, `mem_addr`={request tag, set, counter, 00}, words 0 to N−1 in ascending order.
  - On `mem_ack`, `mem_rdata` is written into the line.
  - After the last word: set valid and the new tag, clear dirty, return to IDLE.
  - The held request then hits, and a write is merged at that point (write-allocate).
- `miss` is 1 throughout WB and FILL.
- The core holds `addr`, `rd_req`, `wr_req`, `wr_be` and `wr_data` stable while `miss`=1. Changes in those cycles are not tracked.
- `rd_req` and `wr_req` both high: treated as a write; `rd_data` is don't-care.
- Memory handshake: a word moves in each cycle with req && `mem_ack`. `mem_ack` may arrive in the same cycle as the request or any later cycle. Request, address and data stay stable until acked. `mem_rd_req` and `mem_wr_req` are never high together.
- Reset effects:
  - Clears all valid and dirty bits.
  - FSM goes to IDLE, word counter to 0.
  - `rd_data`=0 and all memory requests 0 from the first cycle after the reset edge.
  - Reset during WB or FILL aborts the transfer and discards the partial line.
- Data arrays are not reset.

## Timing
- Read hit: request accepted in cycle N; `rd_data` valid in N+1 and held until the next read hit.
- Write hit: array updated at the end of cycle N.
- Miss, with `mem_ack` in every requested cycle (N = 2^`LINE_ADDR_LEN`):
  - Clean victim: `miss` high for N+1 cycles.
  - Dirty victim: `miss` high for 2N+1 cycles.
  - Defaults: 9 and 17 cycles.
- The replay hit cycle has `miss`=0; `rd_data` follows one cycle later.
- Each extra memory wait cycle extends `miss` by one cycle.

## Configuration
- `DCACHE_STATS_EN` defined:
  - Adds outputs `hit_count out 32` and `miss_count out 32`. Both are 0 after reset and wrap at 2^32.
  - `hit_count` increments once per IDLE hit, including replay hits.
  - `miss_count` increments once per IDLE→WB/FILL transition.
- `DCACHE_STATS_EN` undefined: neither the ports nor the counters exist, and all other behaviour is identical.

## Test plan
- After reset, read 0x00000100 with memory word k returning 0xA0+k: `miss` high 9 cycles; the FILL addresses are 0x100 through 0x11C; the replay hit returns `rd_data`=0xA0 one cycle later. A following read of 0x104 hits with `miss`=0 and returns 0xA1.
- Write 0xDEADBEEF to 0x108 with `wr_be`=0011 on the resident line: no miss; a following read returns 0xBEEF in the low half and keeps the original upper bytes. The line is now dirty.
- Read 0x00000300 (same set 8, different tag): `miss` high 17 cycles; 8 writes to 0x100–0x11C, with the modified word at 0x108, precede 8 reads of 0x300–0x31C.
- Write miss to 0x00000500 (clean victim), `wr_be`=1111, data 0x12345678: line refilled, then merged; a following read of 0x500 returns 0x12345678.
- Assert `rst` for one cycle during FILL word 3: `miss` and the memory requests go to 0 the next cycle, and re-reading the same address misses again.
- With `DCACHE_STATS_EN`, after the sequence above (no reset): expect specific `hit_count` and `miss_count` values, computed by the bench's reference model.
